ball_mover: RTL and testbench
=============================

Name: ball_mover

Overview:
Per-frame motion engine for the ball set.
- Owns CNT ball positions, direction bits and active flags.
- Advances each active ball once per video frame: wall bounce, paddle bounce, loss at the bottom edge.
- Drives packed xs/ys/active buses consumed by the ball renderer; sits between the frame-timing generator and the pixel pipeline.

Parameters:
CNT, 3, number of ball slots
X_MAX, 640, visible width in pixels
Y_MAX, 480, visible height in pixels
PADDLE_Y, 440, y coordinate of paddle top surface

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse at start of vertical blanking
launch  in  1  one-cycle pulse; serve ball 0
split  in  1  one-cycle pulse; multiball request (see Optional Feature)
speed  in  3  pixels moved per axis per frame, 0..7
radius  in  6  ball radius in pixels
paddle_x  in  10  paddle left edge
paddle_w  in  8  paddle width
xs  out  CNT*10  packed x centres, slot i at [i*10+:10]
ys  out  CNT*10  packed y centres, slot i at [i*10+:10]
active  out  CNT  slot-valid flags
update_done  out  1  one-cycle pulse after the last slot of a pass
all_lost  out  1  one-cycle pulse when a pass leaves active==0 after it was non-zero

Behaviour:
- Reset: xs=0, ys=0, active=0, all dx/dy bits=0 (0=right/down, 1=left/up), state IDLE, idx=0, update_done=0, all_lost=0.
- States:
  - IDLE: on frame_tick -> UPDATE, idx=0, latch was_any=|active.
  - UPDATE: process slot idx in one cycle. idx==CNT-1 -> DONE, else idx+1.
  - DONE: update_done=1 for one cycle; all_lost=1 if was_any && active==0. -> IDLE.
- Pass latency: frame_tick edge to update_done = CNT+1 cycles. frame_tick outside IDLE is ignored.
- Slot update (inactive slots untouched): all arithmetic in 11-bit unsigned; no 10-bit wrap.
  - X axis, left: if x < radius+speed then x=radius, dx=0; else x-=speed.
  - X axis, right: if x+speed > X_MAX-1-radius then x=X_MAX-1-radius, dx=1; else x+=speed.
  - Y axis, up: if y < radius+speed then y=radius, dy=0; else y-=speed.
  - Y axis, down, paddle: if y+radius <= PADDLE_Y < y+radius+speed and paddle_x <= x <= paddle_x+paddle_w, then y=PADDLE_Y-radius, dy=1.
  - Y axis, down, loss: else if y+speed > Y_MAX-1-radius then active[idx]=0 and x,y hold.
  - Y axis, down, otherwise: y+=speed.
  - X and Y are resolved independently in the same cycle.
- launch: accepted only in IDLE with active==0. Sets slot 0 x=paddle_x+paddle_w/2, y=PADDLE_Y-radius-1, dx=0, dy=1, active[0]=1. Ignored otherwise.
- launch and frame_tick in the same IDLE cycle: both act. Slot 0 is loaded and UPDATE starts; the pass moves the new ball.
- speed=0: positions hold. Boundary checks still clamp (x<radius -> x=radius).
- rst mid-pass: returns everything to reset values immediately; no update_done.

Optional Feature:
Macro BALL_SPLIT_EN.
- Defined: split pulse in IDLE with active!=0 and at least one free slot. In one cycle, every inactive slot j copies x,y,dy of the lowest-index active slot, takes dx = source dx XOR j[0], and is set active. split outside IDLE or coinciding with frame_tick is ignored.
- Not defined: split port present but ignored; no split logic synthesised.

Decomposition:
- Package ball_pkg: X_MAX/Y_MAX/PADDLE_Y defaults, coordinate width constant (10), state enum {IDLE, UPDATE, DONE}.
- Sub-module ball_step: combinational single-ball next-state. Inputs x, y, dx, dy, speed, radius, paddle_x, paddle_w. Outputs nx, ny, ndx, ndy, lost. Instantiated once and muxed by idx.

Test Plan:
- Reset, then launch with paddle_x=300, paddle_w=64, radius=4 -> active=001, x0=332, y0=435, dx=0, dy=1.
- Ball x=630, dx=0, speed=7, radius=4, one frame_tick -> x=635, dx=1; update_done exactly 4 cycles after tick (CNT=3).
- Ball y=433, dy=0, x=320, paddle 300..364, speed=4, radius=4 -> y=436, dy=1. Same with x=200 -> y=437, no bounce.
- Single ball y=474, dy=0, speed=3, radius=4 -> active=000, all_lost pulses once in DONE; next pass no all_lost.
- frame_tick asserted again 1 cycle into a pass -> ignored, exactly one update_done. rst during UPDATE -> all outputs 0 next cycle.
- BALL_SPLIT_EN defined, slot 0 active at (100,200) dx=0 -> split gives active=111, slot1 dx=1, slot2 dx=0, all at (100,200). Macro undefined -> active stays 001.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared constants and state encoding for the ball motion engine.
package ball_pkg;

    localparam int COORD_W       = 10;
    localparam int BALL_X_MAX    = 640;
    localparam int BALL_Y_MAX    = 480;
    localparam int BALL_PADDLE_Y = 440;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DONE
    } state_t;

endpackage

// File: rtl/ball_step.sv
// Combinational next-position logic for a single ball: wall bounce, paddle bounce, bottom loss.
module ball_step import ball_pkg::*; #(
    parameter int X_MAX    = BALL_X_MAX,
    parameter int Y_MAX    = BALL_Y_MAX,
    parameter int PADDLE_Y = BALL_PADDLE_Y
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               dx,
    input  logic               dy,
    input  logic [2:0]         speed,
    input  logic [5:0]         radius,
    input  logic [COORD_W-1:0] paddle_x,
    input  logic [7:0]         paddle_w,
    output logic [COORD_W-1:0] nx,
    output logic [COORD_W-1:0] ny,
    output logic               ndx,
    output logic               ndy,
    output logic               lost
);

    // One extra bit of headroom so sums near the right/bottom edge never wrap.
    localparam int W = COORD_W + 1;

    logic [W-1:0] xw;
    logic [W-1:0] yw;
    logic [W-1:0] rw;
    logic [W-1:0] sw;
    logic [W-1:0] py;
    logic [W-1:0] x_lim;
    logic [W-1:0] y_lim;
    logic [W-1:0] pad_hi;

    always_comb begin
        xw     = W'(x);
        yw     = W'(y);
        rw     = W'(radius);
        sw     = W'(speed);
        py     = W'(PADDLE_Y);
        x_lim  = W'(X_MAX - 1) - rw;
        y_lim  = W'(Y_MAX - 1) - rw;
        pad_hi = W'(paddle_x) + W'(paddle_w);

        nx   = x;
        ny   = y;
        ndx  = dx;
        ndy  = dy;
        lost = 1'b0;

        if (dx) begin
            if (xw < rw + sw) begin
                nx  = COORD_W'(radius);
                ndx = 1'b0;
            end else begin
                nx = COORD_W'(xw - sw);
            end
        end else begin
            if (xw + sw > x_lim) begin
                nx  = COORD_W'(x_lim);
                ndx = 1'b1;
            end else begin
                nx = COORD_W'(xw + sw);
            end
        end

        if (dy) begin
            if (yw < rw + sw) begin
                ny  = COORD_W'(radius);
                ndy = 1'b0;
            end else begin
                ny = COORD_W'(yw - sw);
            end
        end else if ((yw + rw <= py) && (py < yw + rw + sw) &&
                     (xw >= W'(paddle_x)) && (xw <= pad_hi)) begin
            ny  = COORD_W'(py - rw);
            ndy = 1'b1;
        end else if (yw + sw > y_lim) begin
            lost = 1'b1;
        end else begin
            ny = COORD_W'(yw + sw);
        end

        // A lost ball freezes where it was rather than drifting sideways.
        if (lost) begin
            nx  = x;
            ndx = dx;
        end
    end

endmodule

// File: rtl/ball_mover.sv
// Per-frame motion engine for CNT ball slots; one slot is advanced per cycle after frame_tick.
// Optional multiball split enabled by defining BALL_SPLIT_EN.
module ball_mover import ball_pkg::*; #(
    parameter int CNT      = 3,
    parameter int X_MAX    = BALL_X_MAX,
    parameter int Y_MAX    = BALL_Y_MAX,
    parameter int PADDLE_Y = BALL_PADDLE_Y
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   launch,
    input  logic                   split,
    input  logic [2:0]             speed,
    input  logic [5:0]             radius,
    input  logic [COORD_W-1:0]     paddle_x,
    input  logic [7:0]             paddle_w,
    output logic [CNT*COORD_W-1:0] xs,
    output logic [CNT*COORD_W-1:0] ys,
    output logic [CNT-1:0]         active,
    output logic                   update_done,
    output logic                   all_lost
);

    localparam int IDX_W = (CNT > 1) ? $clog2(CNT) : 1;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     was_any_q, was_any_d;
    logic [CNT*COORD_W-1:0]   xs_q, xs_d;
    logic [CNT*COORD_W-1:0]   ys_q, ys_d;
    logic [CNT-1:0]           dx_q, dx_d;
    logic [CNT-1:0]           dy_q, dy_d;
    logic [CNT-1:0]           active_q, active_d;
    logic                     update_done_q, update_done_d;
    logic                     all_lost_q, all_lost_d;

    logic [COORD_W-1:0]       step_nx;
    logic [COORD_W-1:0]       step_ny;
    logic                     step_ndx;
    logic                     step_ndy;
    logic                     step_lost;

    ball_step #(
        .X_MAX    (X_MAX),
        .Y_MAX    (Y_MAX),
        .PADDLE_Y (PADDLE_Y)
    ) u_step (
        .x        (xs_q[int'(idx_q)*COORD_W +: COORD_W]),
        .y        (ys_q[int'(idx_q)*COORD_W +: COORD_W]),
        .dx       (dx_q[idx_q]),
        .dy       (dy_q[idx_q]),
        .speed    (speed),
        .radius   (radius),
        .paddle_x (paddle_x),
        .paddle_w (paddle_w),
        .nx       (step_nx),
        .ny       (step_ny),
        .ndx      (step_ndx),
        .ndy      (step_ndy),
        .lost     (step_lost)
    );

`ifdef BALL_SPLIT_EN
    logic [IDX_W-1:0] src_idx;

    // Lowest-index active slot is the one every new ball is cloned from.
    always_comb begin
        src_idx = '0;
        for (int i = CNT - 1; i >= 0; i--) begin
            if (active_q[i]) src_idx = IDX_W'(i);
        end
    end
`else
    logic split_unused;
    assign split_unused = split;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        was_any_d     = was_any_q;
        xs_d          = xs_q;
        ys_d          = ys_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        active_d      = active_q;
        update_done_d = 1'b0;
        all_lost_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (launch && (active_q == '0)) begin
                    xs_d[0 +: COORD_W] = paddle_x + COORD_W'(paddle_w >> 1);
                    ys_d[0 +: COORD_W] = COORD_W'(PADDLE_Y) - COORD_W'(radius) - COORD_W'(1);
                    dx_d[0]            = 1'b0;
                    dy_d[0]            = 1'b1;
                    active_d[0]        = 1'b1;
                end
`ifdef BALL_SPLIT_EN
                else if (split && !frame_tick && (active_q != '0) && (active_q != '1)) begin
                    for (int j = 0; j < CNT; j++) begin
                        if (!active_q[j]) begin
                            xs_d[j*COORD_W +: COORD_W] = xs_q[int'(src_idx)*COORD_W +: COORD_W];
                            ys_d[j*COORD_W +: COORD_W] = ys_q[int'(src_idx)*COORD_W +: COORD_W];
                            dy_d[j]     = dy_q[src_idx];
                            dx_d[j]     = dx_q[src_idx] ^ j[0];
                            active_d[j] = 1'b1;
                        end
                    end
                end
`endif
                if (frame_tick) begin
                    state_d   = UPDATE;
                    idx_d     = '0;
                    was_any_d = |active_q;
                end
            end
            UPDATE: begin
                if (active_q[idx_q]) begin
                    xs_d[int'(idx_q)*COORD_W +: COORD_W] = step_nx;
                    ys_d[int'(idx_q)*COORD_W +: COORD_W] = step_ny;
                    dx_d[idx_q] = step_ndx;
                    dy_d[idx_q] = step_ndy;
                    if (step_lost) active_d[idx_q] = 1'b0;
                end
                if (idx_q == IDX_W'(CNT - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                update_done_d = 1'b1;
                all_lost_d    = was_any_q && (active_q == '0);
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            was_any_q     <= 1'b0;
            xs_q          <= '0;
            ys_q          <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            active_q      <= '0;
            update_done_q <= 1'b0;
            all_lost_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            was_any_q     <= was_any_d;
            xs_q          <= xs_d;
            ys_q          <= ys_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            active_q      <= active_d;
            update_done_q <= update_done_d;
            all_lost_q    <= all_lost_d;
        end
    end

    assign xs          = xs_q;
    assign ys          = ys_q;
    assign active      = active_q;
    assign update_done = update_done_q;
    assign all_lost    = all_lost_q;

endmodule

// File: tb/tb_ball_mover.sv
// Directed self-checking bench for ball_mover; split expectations follow BALL_SPLIT_EN.
module tb_ball_mover;

    localparam int CNT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_tick = 1'b0;
    logic              launch = 1'b0;
    logic              split = 1'b0;
    logic [2:0]        speed = 3'd0;
    logic [5:0]        radius = 6'd4;
    logic [9:0]        paddle_x = 10'd0;
    logic [7:0]        paddle_w = 8'd0;
    logic [CNT*10-1:0] xs;
    logic [CNT*10-1:0] ys;
    logic [CNT-1:0]    active;
    logic              update_done;
    logic              all_lost;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ball_mover #(.CNT(CNT)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .launch      (launch),
        .split       (split),
        .speed       (speed),
        .radius      (radius),
        .paddle_x    (paddle_x),
        .paddle_w    (paddle_w),
        .xs          (xs),
        .ys          (ys),
        .active      (active),
        .update_done (update_done),
        .all_lost    (all_lost)
    );

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic tk, input logic ln, input logic sp);
        frame_tick = tk;
        launch     = ln;
        split      = sp;
        step_clk();
        frame_tick = 1'b0;
        launch     = 1'b0;
        split      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
    endtask

    // Leaves the bench #1 after the edge where update_done is high.
    task automatic run_frame(input logic [2:0] spd);
        speed = spd;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (4) step_clk();
    endtask

    // Launch at (332,435) moving up, bounce off the top and come down to (80,433) moving down, left.
    task automatic travel_to_433();
        do_reset();
        paddle_x = 10'd300;
        paddle_w = 8'd64;
        radius   = 6'd4;
        applyStimulus(1'b0, 1'b1, 1'b0);
        paddle_x = 10'd1000;
        paddle_w = 8'd0;
        repeat (123) run_frame(3'd7);
        run_frame(3'd2);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        step_clk();
        checkOutput("rst_active", active, 0);
        checkOutput("rst_xs", xs, 0);
        checkOutput("rst_ys", ys, 0);
        checkOutput("rst_done", update_done, 0);
        checkOutput("rst_lost", all_lost, 0);
        rst = 1'b0;

        paddle_x = 10'd300;
        paddle_w = 8'd64;
        radius   = 6'd4;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("launch_active", active, 3'b001);
        checkOutput("launch_x0", xs[0+:10], 332);
        checkOutput("launch_y0", ys[0+:10], 435);

        paddle_x = 10'd100;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("launch_ignored_x0", xs[0+:10], 332);

        applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef BALL_SPLIT_EN
        checkOutput("split_active", active, 3'b111);
        checkOutput("split_x1", xs[10+:10], 332);
        checkOutput("split_y1", ys[10+:10], 435);
        checkOutput("split_x2", xs[20+:10], 332);
        checkOutput("split_y2", ys[20+:10], 435);
        run_frame(3'd7);
        checkOutput("split_mv_x0", xs[0+:10], 339);
        checkOutput("split_mv_x1", xs[10+:10], 325);
        checkOutput("split_mv_x2", xs[20+:10], 339);
        checkOutput("split_mv_y1", ys[10+:10], 428);
`else
        checkOutput("split_off_active", active, 3'b001);
        checkOutput("split_off_x1", xs[10+:10], 0);
`endif

        do_reset();
        paddle_x = 10'd598;
        paddle_w = 8'd64;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("wall_start_x0", xs[0+:10], 630);
        speed = 3'd7;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lat_e0", update_done, 0);
        for (int i = 1; i <= 4; i++) begin
            step_clk();
            checkOutput($sformatf("lat_e%0d", i), update_done, (i == 4) ? 1 : 0);
        end
        checkOutput("wall_x0", xs[0+:10], 635);
        checkOutput("wall_y0", ys[0+:10], 428);
        step_clk();
        checkOutput("done_single_cycle", update_done, 0);
        run_frame(3'd7);
        checkOutput("wall_back_x0", xs[0+:10], 628);
        checkOutput("wall_back_y0", ys[0+:10], 421);

        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        n = 0;
        repeat (8) begin
            step_clk();
            if (update_done) n++;
        end
        checkOutput("retick_done_count", n, 1);
        checkOutput("retick_x0", xs[0+:10], 621);

        applyStimulus(1'b1, 1'b0, 1'b0);
        step_clk();
        rst = 1'b1;
        step_clk();
        checkOutput("midrst_active", active, 0);
        checkOutput("midrst_xs", xs, 0);
        checkOutput("midrst_ys", ys, 0);
        checkOutput("midrst_done", update_done, 0);
        rst = 1'b0;
        n = 0;
        repeat (6) begin
            step_clk();
            if (update_done) n++;
        end
        checkOutput("midrst_no_done", n, 0);

        travel_to_433();
        checkOutput("travel_x0", xs[0+:10], 80);
        checkOutput("travel_y0", ys[0+:10], 433);
        paddle_x = 10'd60;
        paddle_w = 8'd64;
        run_frame(3'd4);
        checkOutput("paddle_y0", ys[0+:10], 436);
        checkOutput("paddle_x0", xs[0+:10], 76);
        run_frame(3'd4);
        checkOutput("paddle_up_y0", ys[0+:10], 432);

        travel_to_433();
        paddle_x = 10'd200;
        paddle_w = 8'd64;
        run_frame(3'd4);
        checkOutput("miss_y0", ys[0+:10], 437);
        checkOutput("miss_active", active, 3'b001);
        paddle_x = 10'd1000;
        paddle_w = 8'd0;
        repeat (5) run_frame(3'd7);
        run_frame(3'd2);
        checkOutput("pre_loss_y0", ys[0+:10], 474);
        checkOutput("pre_loss_x0", xs[0+:10], 39);
        checkOutput("pre_loss_all_lost", all_lost, 0);
        run_frame(3'd3);
        checkOutput("loss_active", active, 0);
        checkOutput("loss_all_lost", all_lost, 1);
        checkOutput("loss_done", update_done, 1);
        checkOutput("loss_hold_x0", xs[0+:10], 39);
        checkOutput("loss_hold_y0", ys[0+:10], 474);
        step_clk();
        checkOutput("loss_pulse_end", all_lost, 0);
        run_frame(3'd3);
        checkOutput("empty_pass_done", update_done, 1);
        checkOutput("empty_pass_all_lost", all_lost, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
